concat_merge_pipe: RTL and testbench
====================================

// Module: concat_merge_pipe
// PURPOSE
//  Parametrised, pipelined shift-and-merge stage for PIM partial results. Each lane shifts a narrow
//  operand A and a wide operand B left by per-lane weight amounts, then per-lane mode selects
//  split (A to nonconcat, B dropped), OR-concat, or ADD-merge. Sits between compute array and
//  accumulator; adds valid/ready flow control, overlap detection and overflow flags.
// PARAMETERS
//  N_LANE  12  lanes processed per beat
//  A_W     4   operand A width (narrow compute result)
//  B_W     6   operand B width (wide compute result)
//  SH_W    5   shift-amount width per operand
//  OUT_W   24  lane output width
//  CNT_W   16  overlap counter width
// PORTS
//  clk         in   1            clock, all state on rising edge
//  reset       in   1            synchronous, active-high
//  in_valid    in   1            input beat valid
//  in_ready    out  1            stage 1 can accept
//  computeA    in   N_LANE*A_W   lane i at [i*A_W+:A_W]
//  computeB    in   N_LANE*B_W   lane i at [i*B_W+:B_W]
//  weightA     in   N_LANE*SH_W  shift for A, lane i at [i*SH_W+:SH_W]
//  weightB     in   N_LANE*SH_W  shift for B
//  laneMode    in   N_LANE*2     per-lane mode, travels with the beat
//  clr_cnt     in   1            clears ovlp_cnt (same cycle as a hit: clear wins, hit dropped)
//  out_valid   out  1            output beat valid
//  out_ready   in   1            downstream accepts
//  concatOut   out  N_LANE*OUT_W merged lanes (OR/ADD mode), else 0
//  nonconcatOut out N_LANE*OUT_W split lanes (A shifted), else 0
//  lane_ovf    out  N_LANE       shift dropped set bits past OUT_W-1 (either operand)
//  lane_ovlp   out  N_LANE       OR mode and shifted A & shifted B != 0
//  ovlp_cnt    out  CNT_W        saturating count of lane_ovlp bits accepted downstream
// BEHAVIOUR
//  Reset: in_ready=1 after reset; out_valid, concatOut, nonconcatOut, lane_ovf, lane_ovlp, ovlp_cnt=0;
//   internal s1_v/s2_v=0. Reset mid-operation discards in-flight beats; no partial output.
//  Modes: 2'b00 SPLIT nonconcat=A<<wA; 01 OR concat=(A<<wA)|(B<<wB); 10 ADD concat=(A<<wA)+(B<<wB)
//   truncated to OUT_W (carry out sets lane_ovf); 11 reserved = zero both outputs, no flags.
//  Shifts in OUT_W bits: zero-extend, shift, keep [OUT_W-1:0]; shift >= OUT_W yields 0, ovf if operand!=0.
//  Pipeline: S1 registers shifted A,B, mode and ovf per lane; S2 registers merge, ovlp, outputs.
//   s2_en = !s2_v | out_ready; s1_en = !s1_v | s2_en; in_ready = s1_en (combinational).
//   Latency 2 cycles with out_ready=1; throughput 1 beat/cycle; no bubbles under continuous flow.
//  Stall: out_valid && !out_ready holds all outputs stable; S1 holds if S2 full; both full -> in_ready=0.
//  Data regs load only on their stage enable with valid input; when not valid, data holds (not zeroed).
//  ovlp_cnt += popcount(lane_ovlp) on out_valid&out_ready; saturates at all-ones; clr_cnt resets to 0.
// STRUCTURE
//  Shared package concat_pkg: MODE_SPLIT/OR/ADD/RSVD encodings, default OUT_W/SH_W.
//  One sub-module: shift_lane (IN_W, SH_W, OUT_W) -> shifted value + ovf, combinational,
//   instantiated 2*N_LANE times; S1/S2 registers and handshake live in concat_merge_pipe.
// TESTING
//  1 SPLIT: lane0 A=4'hF,wA=4,mode 00 -> nonconcat lane0=24'h0000F0, concat=0, out 2 cycles later.
//  2 OR overlap: A=4'h3,wA=0,B=6'h01,wB=1, mode 01 -> concat=24'h3, lane_ovlp[0]=1, ovlp_cnt +1.
//  3 ADD+ovf: A=4'hF,wA=20,B=6'h3F,wB=20, mode 10 -> concat=24'hE00000 region truncated, lane_ovf=1.
//  4 Backpressure: stream 5 beats, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted,
//    outputs held stable, all 5 beats emerge in order with no loss/duplication.
//  5 Reset mid-stream: reset with S1,S2 full -> next cycle out_valid=0, ovlp_cnt=0, in_ready=1.
//  6 Counter: N_LANE overlapping lanes for 2^CNT_W beats -> ovlp_cnt saturates; clr_cnt+hit -> 0.

Source files
------------

// File: rtl/concat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : concat_pkg
// Purpose  : Shared definitions for the concat/merge pipeline.
//            Declares the per-lane mode encodings and the default
//            shift-amount and lane-output widths.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package concat_pkg;

    // Per-lane operating mode, carried with each beat
    typedef enum logic [1:0] {
        MODE_SPLIT = 2'b00,  // A shifted to nonconcatOut, B dropped
        MODE_OR    = 2'b01,  // concatOut = shifted A | shifted B
        MODE_ADD   = 2'b10,  // concatOut = shifted A + shifted B (truncated)
        MODE_RSVD  = 2'b11   // both outputs zero, no flags
    } lane_mode_e;

    localparam int DEF_OUT_W = 24;
    localparam int DEF_SH_W  = 5;

endpackage : concat_pkg
`default_nettype wire

// File: rtl/concat_merge_pipe_shift_lane.sv
`default_nettype none
// ============================================================================
// Module   : shift_lane
// Purpose  : Combinational left shift of a narrow operand into an OUT_W-bit
//            field. Flags any set operand bit pushed past bit OUT_W-1
//            (including shift amounts >= OUT_W).
// Ports    : value   in  IN_W   operand, zero-extended before shifting
//            shamt   in  SH_W   left-shift amount
//            shifted out OUT_W  low OUT_W bits of the shifted operand
//            ovf     out 1      a set bit was lost above OUT_W-1
// Revision : 1.0  initial release
// ============================================================================
module shift_lane
    import concat_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int SH_W  = DEF_SH_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [IN_W-1:0]  value,
    input  logic [SH_W-1:0]  shamt,
    output logic [OUT_W-1:0] shifted,
    output logic             ovf
);

    // Wide enough that no operand bit can fall off the top for any shift
    // amount, so everything above OUT_W-1 is exactly what was dropped.
    localparam int c_ext_w = OUT_W + (1 << SH_W);

    logic [c_ext_w-1:0] w_ext;

    assign w_ext   = {{(c_ext_w - IN_W){1'b0}}, value} << shamt;
    assign shifted = w_ext[OUT_W-1:0];
    assign ovf     = |w_ext[c_ext_w-1:OUT_W];

endmodule : shift_lane
`default_nettype wire

// File: rtl/concat_merge_pipe.sv
`default_nettype none
// ============================================================================
// Module   : concat_merge_pipe
// Purpose  : Two-stage pipelined shift-and-merge of PIM partial results.
//            S1 registers the per-lane shifted operands, mode and shift
//            overflow; S2 registers the merged outputs, overlap flags and
//            final overflow. Valid/ready handshake with a saturating
//            overlap counter.
// Ports    : clk, reset                  clock / synchronous active-high reset
//            in_valid, in_ready          input handshake
//            computeA, computeB          packed per-lane operands
//            weightA, weightB            packed per-lane shift amounts
//            laneMode                    packed per-lane 2-bit mode
//            clr_cnt                     clear overlap counter (beats a hit)
//            out_valid, out_ready        output handshake
//            concatOut, nonconcatOut     packed per-lane OUT_W results
//            lane_ovf, lane_ovlp         per-lane overflow / OR-overlap flags
//            ovlp_cnt                    saturating overlap count
// Revision : 1.0  initial release
// ============================================================================
module concat_merge_pipe
    import concat_pkg::*;
#(
    parameter int N_LANE = 12,
    parameter int A_W    = 4,
    parameter int B_W    = 6,
    parameter int SH_W   = DEF_SH_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_LANE*A_W-1:0]   computeA,
    input  logic [N_LANE*B_W-1:0]   computeB,
    input  logic [N_LANE*SH_W-1:0]  weightA,
    input  logic [N_LANE*SH_W-1:0]  weightB,
    input  logic [N_LANE*2-1:0]     laneMode,
    input  logic                    clr_cnt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_LANE*OUT_W-1:0] concatOut,
    output logic [N_LANE*OUT_W-1:0] nonconcatOut,
    output logic [N_LANE-1:0]       lane_ovf,
    output logic [N_LANE-1:0]       lane_ovlp,
    output logic [CNT_W-1:0]        ovlp_cnt
);

    // ------------------------------------------------------------------
    // Shifters and stage-1 overflow selection
    // ------------------------------------------------------------------
    logic [N_LANE-1:0][OUT_W-1:0] w_sa;
    logic [N_LANE-1:0][OUT_W-1:0] w_sb;
    logic [N_LANE-1:0]            w_ova;
    logic [N_LANE-1:0]            w_ovb;
    logic [N_LANE-1:0]            w_s1_ovf;

    for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane
        logic [1:0] w_mode;

        assign w_mode = laneMode[gi*2 +: 2];

        shift_lane #(.IN_W(A_W), .SH_W(SH_W), .OUT_W(OUT_W)) u_shift_a (
            .value   (computeA[gi*A_W +: A_W]),
            .shamt   (weightA[gi*SH_W +: SH_W]),
            .shifted (w_sa[gi]),
            .ovf     (w_ova[gi])
        );

        shift_lane #(.IN_W(B_W), .SH_W(SH_W), .OUT_W(OUT_W)) u_shift_b (
            .value   (computeB[gi*B_W +: B_W]),
            .shamt   (weightB[gi*SH_W +: SH_W]),
            .shifted (w_sb[gi]),
            .ovf     (w_ovb[gi])
        );

        // B never reaches an output in SPLIT mode, so its lost bits are not
        // reported there; reserved mode raises no flags at all.
        assign w_s1_ovf[gi] = (w_mode == MODE_SPLIT) ? w_ova[gi] :
                              (w_mode == MODE_RSVD)  ? 1'b0      :
                                                       (w_ova[gi] | w_ovb[gi]);
    end

    // ------------------------------------------------------------------
    // Handshake: a stage advances when it is empty or its successor moves
    // ------------------------------------------------------------------
    logic r_s1_v;
    logic r_s2_v;
    logic w_s2_en;
    logic w_s1_en;

    assign w_s2_en  = !r_s2_v || out_ready;
    assign w_s1_en  = !r_s1_v || w_s2_en;
    assign in_ready = w_s1_en;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [N_LANE-1:0][OUT_W-1:0] r_s1_sa;
    logic [N_LANE-1:0][OUT_W-1:0] r_s1_sb;
    logic [N_LANE-1:0][1:0]       r_s1_mode;
    logic [N_LANE-1:0]            r_s1_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_v    <= 1'b0;
            r_s1_sa   <= '0;
            r_s1_sb   <= '0;
            r_s1_mode <= '0;
            r_s1_ovf  <= '0;
        end else if (w_s1_en) begin
            r_s1_v <= in_valid;
            // Data only moves with a real beat; bubbles leave it untouched
            if (in_valid) begin
                r_s1_sa   <= w_sa;
                r_s1_sb   <= w_sb;
                r_s1_mode <= laneMode;
                r_s1_ovf  <= w_s1_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 merge logic
    // ------------------------------------------------------------------
    logic [N_LANE-1:0][OUT_W-1:0] w_cat;
    logic [N_LANE-1:0][OUT_W-1:0] w_ncat;
    logic [N_LANE-1:0]            w_ovf;
    logic [N_LANE-1:0]            w_ovlp;
    logic [OUT_W:0]               w_sum;

    always_comb begin
        w_cat  = '0;
        w_ncat = '0;
        w_ovf  = '0;
        w_ovlp = '0;
        w_sum  = '0;
        for (int i = 0; i < N_LANE; i++) begin
            w_sum = {1'b0, r_s1_sa[i]} + {1'b0, r_s1_sb[i]};
            case (r_s1_mode[i])
                MODE_SPLIT: begin
                    w_ncat[i] = r_s1_sa[i];
                    w_ovf[i]  = r_s1_ovf[i];
                end
                MODE_OR: begin
                    w_cat[i]  = r_s1_sa[i] | r_s1_sb[i];
                    w_ovf[i]  = r_s1_ovf[i];
                    w_ovlp[i] = |(r_s1_sa[i] & r_s1_sb[i]);
                end
                MODE_ADD: begin
                    // Carry out of the OUT_W-bit sum is lost data too
                    w_cat[i] = w_sum[OUT_W-1:0];
                    w_ovf[i] = r_s1_ovf[i] | w_sum[OUT_W];
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (the module outputs)
    // ------------------------------------------------------------------
    logic [N_LANE-1:0][OUT_W-1:0] r_cat;
    logic [N_LANE-1:0][OUT_W-1:0] r_ncat;
    logic [N_LANE-1:0]            r_ovf;
    logic [N_LANE-1:0]            r_ovlp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_v <= 1'b0;
            r_cat  <= '0;
            r_ncat <= '0;
            r_ovf  <= '0;
            r_ovlp <= '0;
        end else if (w_s2_en) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_cat  <= w_cat;
                r_ncat <= w_ncat;
                r_ovf  <= w_ovf;
                r_ovlp <= w_ovlp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating overlap counter, counts only beats taken downstream
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_pop;
    logic [CNT_W:0]   w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_LANE; i++) begin
            w_pop = w_pop + {{CNT_W{1'b0}}, r_ovlp[i]};
        end
    end

    assign w_cnt_sum  = {1'b0, r_cnt} + w_pop;
    assign w_cnt_next = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (r_s2_v && out_ready) begin
            r_cnt <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid    = r_s2_v;
    assign concatOut    = r_cat;
    assign nonconcatOut = r_ncat;
    assign lane_ovf     = r_ovf;
    assign lane_ovlp    = r_ovlp;
    assign ovlp_cnt     = r_cnt;

endmodule : concat_merge_pipe
`default_nettype wire

// File: tb/tb_concat_merge_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_concat_merge_pipe
// Purpose  : Self-checking bench for concat_merge_pipe. Accepted beats are
//            turned into expected results by an arithmetic reference model
//            and compared in order with the beats taken at the output.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_concat_merge_pipe;

    localparam int N  = 12;
    localparam int AW = 4;
    localparam int BW = 6;
    localparam int SW = 5;
    localparam int OW = 24;
    localparam int CW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk       = 1'b0;
    logic            reset     = 1'b1;
    logic            in_valid  = 1'b0;
    logic            out_ready = 1'b0;
    logic            clr_cnt   = 1'b0;
    logic [N*AW-1:0] computeA  = '0;
    logic [N*BW-1:0] computeB  = '0;
    logic [N*SW-1:0] weightA   = '0;
    logic [N*SW-1:0] weightB   = '0;
    logic [N*2-1:0]  laneMode  = '0;
    logic            in_ready;
    logic            out_valid;
    logic [N*OW-1:0] concatOut;
    logic [N*OW-1:0] nonconcatOut;
    logic [N-1:0]    lane_ovf;
    logic [N-1:0]    lane_ovlp;
    logic [CW-1:0]   ovlp_cnt;

    typedef struct {
        logic [N*OW-1:0] c;
        logic [N*OW-1:0] n;
        logic [N-1:0]    ovf;
        logic [N-1:0]    ovlp;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    total   = 0;
    int    bad     = 0;
    int    exp_cnt = 0;

    always #5 clk = ~clk;

    concat_merge_pipe #(
        .N_LANE(N), .A_W(AW), .B_W(BW), .SH_W(SW), .OUT_W(OW), .CNT_W(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .computeA     (computeA),
        .computeB     (computeB),
        .weightA      (weightA),
        .weightB      (weightB),
        .laneMode     (laneMode),
        .clr_cnt      (clr_cnt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .concatOut    (concatOut),
        .nonconcatOut (nonconcatOut),
        .lane_ovf     (lane_ovf),
        .lane_ovlp    (lane_ovlp),
        .ovlp_cnt     (ovlp_cnt)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model: expected beat for the current input payload
    function automatic beat_t model_beat();
        beat_t e;
        longint mask;
        mask   = (longint'(1) << OW) - 1;
        e.c    = '0;
        e.n    = '0;
        e.ovf  = '0;
        e.ovlp = '0;
        for (int i = 0; i < N; i++) begin
            longint a, b, sa_full, sb_full, sa, sb, sum;
            bit     oa, ob;
            a       = longint'(computeA[i*AW +: AW]);
            b       = longint'(computeB[i*BW +: BW]);
            sa_full = a * (longint'(1) << weightA[i*SW +: SW]);
            sb_full = b * (longint'(1) << weightB[i*SW +: SW]);
            sa      = sa_full & mask;
            sb      = sb_full & mask;
            oa      = sa_full > mask;
            ob      = sb_full > mask;
            sum     = sa + sb;
            case (laneMode[i*2 +: 2])
                2'b00: begin
                    e.n[i*OW +: OW] = sa[OW-1:0];
                    e.ovf[i]        = oa;
                end
                2'b01: begin
                    e.c[i*OW +: OW] = sa[OW-1:0] | sb[OW-1:0];
                    e.ovf[i]        = oa | ob;
                    e.ovlp[i]       = (sa & sb) != 0;
                end
                2'b10: begin
                    e.c[i*OW +: OW] = sum[OW-1:0];
                    e.ovf[i]        = oa | ob | (sum > mask);
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    // One clock of handshake bookkeeping; performs no comparisons
    task automatic step(input bit v, input bit r, input bit clr);
        beat_t g;
        beat_t e;
        in_valid  = v;
        out_ready = r;
        clr_cnt   = clr;
        #1;
        if (v && in_ready) exp_q.push_back(model_beat());
        if (out_valid && r) begin
            g.c    = concatOut;
            g.n    = nonconcatOut;
            g.ovf  = lane_ovf;
            g.ovlp = lane_ovlp;
            got_q.push_back(g);
            if (got_q.size() <= exp_q.size()) begin
                e = exp_q[got_q.size() - 1];
                exp_cnt = exp_cnt + $countones(e.ovlp);
                if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
            end
        end
        if (clr) exp_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic set_all(input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input logic [SW-1:0] wa, input logic [SW-1:0] wb,
                           input logic [1:0] m);
        for (int i = 0; i < N; i++) begin
            computeA[i*AW +: AW] = a;
            computeB[i*BW +: BW] = b;
            weightA[i*SW +: SW]  = wa;
            weightB[i*SW +: SW]  = wb;
            laneMode[i*2 +: 2]   = m;
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < N; i++) begin
            computeA[i*AW +: AW] = AW'($urandom_range(0, 15));
            computeB[i*BW +: BW] = BW'($urandom_range(0, 63));
            weightA[i*SW +: SW]  = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(0, 31))
                                                               : SW'($urandom_range(0, 20));
            weightB[i*SW +: SW]  = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(0, 31))
                                                               : SW'($urandom_range(0, 18));
            laneMode[i*2 +: 2]   = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        flush();
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (concatOut !== '0 || nonconcatOut !== '0) begin
            bad++; $display("FAIL reset_data got=%h/%h want=0", concatOut, nonconcatOut);
        end
        total++; if (lane_ovf !== '0 || lane_ovlp !== '0 || ovlp_cnt !== '0) begin
            bad++; $display("FAIL reset_flags got ovf=%h ovlp=%h cnt=%h want=0", lane_ovf, lane_ovlp, ovlp_cnt);
        end
    endtask

    task automatic test_split();
        logic [N*OW-1:0] want_n;
        want_n        = '0;
        want_n[23:0]  = 24'h0000F0;
        set_all(4'h0, 6'h00, 5'd0, 5'd0, 2'b00);
        computeA[3:0] = 4'hF;
        weightA[4:0]  = 5'd4;
        step(1, 1, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL split_latency1 out_valid=%b want=0", out_valid); end
        step(0, 1, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL split_latency2 out_valid=%b want=1", out_valid); end
        total++; if (nonconcatOut !== want_n) begin bad++; $display("FAIL split_nonconcat got=%h want=%h", nonconcatOut, want_n); end
        total++; if (concatOut !== '0 || lane_ovf !== '0) begin
            bad++; $display("FAIL split_concat got=%h ovf=%h want=0", concatOut, lane_ovf);
        end
        step(0, 1, 0);
        flush();
    endtask

    task automatic test_or_overlap();
        set_all(4'h0, 6'h00, 5'd0, 5'd0, 2'b11);
        computeA[3:0] = 4'h3;
        computeB[5:0] = 6'h01;
        weightB[4:0]  = 5'd1;
        laneMode[1:0] = 2'b01;
        step(1, 1, 0);
        step(0, 1, 0);
        total++; if (out_valid !== 1'b1 || concatOut[23:0] !== 24'h000003) begin
            bad++; $display("FAIL or_concat got v=%b lane0=%h want v=1 lane0=000003", out_valid, concatOut[23:0]);
        end
        total++; if (lane_ovlp !== 12'h001 || lane_ovf !== 12'h000) begin
            bad++; $display("FAIL or_flags got ovlp=%h ovf=%h want 001/000", lane_ovlp, lane_ovf);
        end
        step(0, 1, 0);
        total++; if (ovlp_cnt !== 16'd1) begin bad++; $display("FAIL or_count got=%0d want=1", ovlp_cnt); end
        flush();
    endtask

    task automatic test_add_ovf();
        set_all(4'h0, 6'h00, 5'd0, 5'd0, 2'b11);
        computeA[3:0] = 4'hF;
        weightA[4:0]  = 5'd20;
        computeB[5:0] = 6'h3F;
        weightB[4:0]  = 5'd20;
        laneMode[1:0] = 2'b10;
        step(1, 1, 0);
        step(0, 1, 0);
        total++; if (concatOut[23:0] !== 24'hE00000) begin
            bad++; $display("FAIL add_concat got=%h want=e00000", concatOut[23:0]);
        end
        total++; if (lane_ovf !== 12'h001 || lane_ovlp !== 12'h000) begin
            bad++; $display("FAIL add_flags got ovf=%h ovlp=%h want 001/000", lane_ovf, lane_ovlp);
        end
        step(0, 1, 0);
        flush();
    endtask

    task automatic test_random_stream();
        flush();
        for (int k = 0; k < 400; k++) begin
            set_rand();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end
        for (int k = 0; k < 10 && got_q.size() < exp_q.size(); k++) step(0, 1, 0);
        total++; if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++;
            if (got_q[k].c !== exp_q[k].c || got_q[k].n !== exp_q[k].n ||
                got_q[k].ovf !== exp_q[k].ovf || got_q[k].ovlp !== exp_q[k].ovlp) begin
                bad++;
                $display("FAIL rand_beat%0d got c=%h n=%h ovf=%h ovlp=%h want c=%h n=%h ovf=%h ovlp=%h", k,
                         got_q[k].c, got_q[k].n, got_q[k].ovf, got_q[k].ovlp,
                         exp_q[k].c, exp_q[k].n, exp_q[k].ovf, exp_q[k].ovlp);
            end
        end
        total++; if (ovlp_cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL rand_ovlp_cnt got=%0d want=%0d", ovlp_cnt, exp_cnt); end
        flush();
    endtask

    task automatic test_backpressure();
        int guard;
        flush();
        set_rand(); step(1, 0, 0);
        set_rand(); step(1, 0, 0);
        total++; if (exp_q.size() !== 2 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_fill accepted=%0d out_valid=%b want 2/1", exp_q.size(), out_valid);
        end
        set_rand();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        step(1, 0, 0);
        total++; if (exp_q.size() !== 2 || out_valid !== 1'b1 ||
                     concatOut !== exp_q[0].c || nonconcatOut !== exp_q[0].n) begin
            bad++; $display("FAIL bp_hold accepted=%0d v=%b c=%h want c=%h", exp_q.size(), out_valid, concatOut, exp_q[0].c);
        end
        guard = 0;
        while (exp_q.size() < 5 && guard < 20) begin
            set_rand(); step(1, 1, 0); guard++;
        end
        for (int k = 0; k < 10 && got_q.size() < exp_q.size(); k++) step(0, 1, 0);
        total++; if (exp_q.size() !== 5 || got_q.size() !== 5) begin
            bad++; $display("FAIL bp_count accepted=%0d emitted=%0d want 5/5", exp_q.size(), got_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++;
            if (got_q[k].c !== exp_q[k].c || got_q[k].n !== exp_q[k].n ||
                got_q[k].ovf !== exp_q[k].ovf || got_q[k].ovlp !== exp_q[k].ovlp) begin
                bad++; $display("FAIL bp_beat%0d got c=%h want c=%h", k, got_q[k].c, exp_q[k].c);
            end
        end
        flush();
    endtask

    task automatic test_reset_mid();
        set_all(4'hF, 6'h0F, 5'd0, 5'd0, 2'b01);
        step(1, 0, 0);
        step(1, 0, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_fill out_valid=%b want=1", out_valid); end
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || ovlp_cnt !== '0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_state got v=%b cnt=%0d rdy=%b want 0/0/1", out_valid, ovlp_cnt, in_ready);
        end
        reset = 1'b0;
        flush();
        exp_cnt = 0;
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        total++; if (got_q.size() !== 1 || exp_q.size() !== 1) begin
            bad++; $display("FAIL rstmid_no_stale emitted=%0d want=1", got_q.size());
        end
        total++; if (ovlp_cnt !== 16'd12) begin bad++; $display("FAIL rstmid_cnt got=%0d want=12", ovlp_cnt); end
        flush();
    endtask

    task automatic test_counter();
        set_all(4'h1, 6'h01, 5'd0, 5'd0, 2'b01);
        for (int k = 0; k < 6000; k++) begin
            step(1, 1, 0);
            if (k == 100) begin
                total++; if (ovlp_cnt !== CW'(exp_cnt)) begin
                    bad++; $display("FAIL cnt_mid got=%0d want=%0d", ovlp_cnt, exp_cnt);
                end
            end
        end
        total++; if (ovlp_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_saturate got=%h want=ffff", ovlp_cnt); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL cnt_flow out_valid=%b want=1", out_valid); end
        step(1, 1, 1);
        total++; if (ovlp_cnt !== 16'd0) begin bad++; $display("FAIL cnt_clear_wins got=%0d want=0", ovlp_cnt); end
        for (int k = 0; k < 4; k++) step(0, 1, 0);
        flush();
    endtask

    initial begin
        test_reset();
        test_split();
        test_or_overlap();
        test_add_ovf();
        test_random_stream();
        test_backpressure();
        test_reset_mid();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_concat_merge_pipe
`default_nettype wire
